// File: rtl/calc_pkg.sv
// calc_pkg: shared state/op encodings, BCD constants and validity helper for the calculator
package calc_pkg;
  localparam int BCD_W = 10;
  localparam int BCD_DIGIT_MAX = 9;
  typedef enum logic [2:0] {LOAD_A = 3'd0, LOAD_B = 3'd1, START = 3'd2, WAIT = 3'd3, SHOW = 3'd4} state_t;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;
  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    return (v[7:4] <= 4'(BCD_DIGIT_MAX)) && (v[3:0] <= 4'(BCD_DIGIT_MAX));
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low button, emitting one pulse per press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_n,
  output logic press_p
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic r_s1, r_s2, r_lvl, r_lvl_d, r_press;
  logic [CW-1:0] r_cnt;
  logic w_settled;
  assign w_settled = (r_s2 != r_lvl) && (r_cnt == CW'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_lvl <= 1'b1;
      r_lvl_d <= 1'b1;
      r_press <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= raw_n;
      r_s2 <= r_s1;
      r_cnt <= (r_s2 == r_lvl || w_settled) ? '0 : r_cnt + 1'b1;
      if (w_settled) r_lvl <= r_s2;
      r_lvl_d <= r_lvl;
      r_press <= r_lvl_d & ~r_lvl;
    end
  assign press_p = r_press;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: calculator control FSM capturing operands, running the ALU with timeout, holding the result
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int ALU_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_n,
  input  logic             clr_n,
  input  logic [BCD_W-1:0] sw_val,
  input  logic             sw_neg,
  input  logic [1:0]       sw_op,
  input  logic             alu_done,
  input  logic [BCD_W-1:0] alu_d,
  input  logic             alu_neg,
  input  logic             alu_ovf,
  output logic [BCD_W-1:0] a_val,
  output logic             a_neg,
  output logic [BCD_W-1:0] b_val,
  output logic             b_neg,
  output logic [1:0]       op,
  output logic             alu_start,
  output logic [BCD_W-1:0] d_val,
  output logic             d_neg,
  output logic             d_ovf,
  output logic             show,
  output logic             bcd_err,
  output logic [2:0]       state_dbg
);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);
  state_t r_state;
  op_t r_op;
  logic [TW-1:0] r_tcnt;
  logic [BCD_W-1:0] r_a, r_b, r_d;
  logic r_an, r_bn, r_dn, r_dovf, r_err;
  logic w_key_p, w_clr_p, w_valid;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (.clk(clk), .rst(rst), .raw_n(key_n), .press_p(w_key_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr (.clk(clk), .rst(rst), .raw_n(clr_n), .press_p(w_clr_p));
  assign w_valid = bcd_valid(sw_val);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= LOAD_A;
      r_tcnt <= '0;
      r_a <= '0; r_an <= 1'b0; r_b <= '0; r_bn <= 1'b0; r_op <= OP_ADD;
      r_d <= '0; r_dn <= 1'b0; r_dovf <= 1'b0; r_err <= 1'b0;
    end else if (w_clr_p) begin
      r_state <= LOAD_A;
      r_a <= '0; r_an <= 1'b0; r_b <= '0; r_bn <= 1'b0; r_op <= OP_ADD;
      r_d <= '0; r_dn <= 1'b0; r_dovf <= 1'b0; r_err <= 1'b0;
    end else begin
      case (r_state)
        LOAD_A: if (w_key_p) begin
          r_err <= ~w_valid;
          if (w_valid) begin
            r_a <= sw_val; r_an <= sw_neg; r_state <= LOAD_B;
          end
        end
        LOAD_B: if (w_key_p) begin
          r_err <= ~w_valid;
          if (w_valid) begin
            r_b <= sw_val; r_bn <= sw_neg; r_op <= op_t'(sw_op); r_state <= START;
          end
        end
        START: begin
          r_tcnt <= '0;
          r_state <= WAIT;
        end
        WAIT:
          if (alu_done) begin
            r_d <= alu_d; r_dn <= alu_neg; r_dovf <= alu_ovf; r_state <= SHOW;
          end else if (r_tcnt == TW'(ALU_TIMEOUT - 1)) begin
            r_d <= '0; r_dn <= 1'b0; r_dovf <= 1'b1; r_state <= SHOW;
          end else r_tcnt <= r_tcnt + 1'b1;
        SHOW: if (w_key_p) r_state <= LOAD_A;
        default: r_state <= LOAD_A;
      endcase
    end
  assign a_val = r_a;
  assign a_neg = r_an;
  assign b_val = r_b;
  assign b_neg = r_bn;
  assign op = r_op;
  assign d_val = r_d;
  assign d_neg = r_dn;
  assign d_ovf = r_dovf;
  assign bcd_err = r_err;
  assign alu_start = (r_state == START);
  assign show = (r_state == SHOW);
  assign state_dbg = r_state;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed plus randomized checks of calc_sequencer against a behavioural model
module tb_calc_sequencer;
  localparam int DB = 4;
  localparam int TO = 16;
  logic clk = 1'b0, rst = 1'b1, key_n = 1'b1, clr_n = 1'b1, sw_neg = 1'b0;
  logic alu_done, alu_neg = 1'b0, alu_ovf = 1'b0;
  logic [9:0] sw_val = '0, alu_d = '0;
  logic [1:0] sw_op = '0;
  logic [9:0] a_val, b_val, d_val;
  logic a_neg, b_neg, alu_start, d_neg, d_ovf, show, bcd_err;
  logic [1:0] op;
  logic [2:0] state_dbg;
  int checks = 0, failures = 0;
  logic [9:0] m_a, m_b, m_d;
  logic m_an, m_bn, m_dn, m_do, m_err;
  logic [1:0] m_op;
  logic [2:0] m_st;
  int alu_delay = -1, late_req = 0, late_ack = 0, start_cnt = 0, wait_len = 0;

  always #5 clk = ~clk;

  calc_sequencer #(.DEBOUNCE_CYCLES(DB), .ALU_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .clr_n(clr_n), .sw_val(sw_val), .sw_neg(sw_neg),
    .sw_op(sw_op), .alu_done(alu_done), .alu_d(alu_d), .alu_neg(alu_neg), .alu_ovf(alu_ovf),
    .a_val(a_val), .a_neg(a_neg), .b_val(b_val), .b_neg(b_neg), .op(op), .alu_start(alu_start),
    .d_val(d_val), .d_neg(d_neg), .d_ovf(d_ovf), .show(show), .bcd_err(bcd_err), .state_dbg(state_dbg)
  );

  // ALU stand-in: answers alu_delay cycles after a start pulse; also observes start pulses and WAIT length
  initial begin : alu_model
    int pend;
    pend = 0;
    alu_done = 1'b0;
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) begin start_cnt++; wait_len = 0; end
      if (state_dbg === 3'd3) wait_len++;
      alu_done = 1'b0;
      if (late_req != late_ack) begin late_ack = late_req; alu_done = 1'b1; end
      else if (pend > 0) begin pend--; alu_done = (pend == 0); end
      else if (alu_start === 1'b1 && alu_delay > 0) pend = alu_delay;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string t);
    chk({t, ".state"}, 32'(state_dbg), 32'(m_st));
    chk({t, ".a_val"}, 32'(a_val), 32'(m_a));
    chk({t, ".a_neg"}, 32'(a_neg), 32'(m_an));
    chk({t, ".b_val"}, 32'(b_val), 32'(m_b));
    chk({t, ".b_neg"}, 32'(b_neg), 32'(m_bn));
    chk({t, ".op"}, 32'(op), 32'(m_op));
    chk({t, ".d_val"}, 32'(d_val), 32'(m_d));
    chk({t, ".d_neg"}, 32'(d_neg), 32'(m_dn));
    chk({t, ".d_ovf"}, 32'(d_ovf), 32'(m_do));
    chk({t, ".bcd_err"}, 32'(bcd_err), 32'(m_err));
    chk({t, ".show"}, 32'(show), 32'(m_st == 3'd4));
    chk({t, ".alu_start"}, 32'(alu_start), 32'(m_st == 3'd2));
  endtask

  task automatic model_clear();
    m_a = '0; m_an = 0; m_b = '0; m_bn = 0; m_op = '0;
    m_d = '0; m_dn = 0; m_do = 0; m_err = 0; m_st = 3'd0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string t);
    for (int i = 0; i < 200 && state_dbg !== s; i++) tick(1);
    chk({t, ".reach"}, 32'(state_dbg), 32'(s));
  endtask

  task automatic press();
    key_n = 1'b0;
    tick(DB + 8);
    key_n = 1'b1;
    tick(DB + 8);
  endtask

  task automatic press_to_show(input string t);
    key_n = 1'b0;
    tick(DB + 8);
    key_n = 1'b1;
    wait_state(3'd4, t);
    tick(DB + 8);
  endtask

  function automatic logic [9:0] rand_bcd();
    return {2'($urandom_range(3)), 4'($urandom_range(9)), 4'($urandom_range(9))};
  endfunction

  // Full A/B/ALU round from LOAD_A; dly>TO or <=0 means the ALU answers too late or never
  task automatic run_calc(input int dly, input string t);
    int s0;
    logic ok;
    m_a = rand_bcd(); m_an = 1'($urandom);
    sw_val = m_a; sw_neg = m_an;
    press();
    m_st = 3'd1; m_err = 0;
    chk({t, ".a_state"}, 32'(state_dbg), 32'(m_st));
    m_b = rand_bcd(); m_bn = 1'($urandom); m_op = 2'($urandom);
    sw_val = m_b; sw_neg = m_bn; sw_op = m_op;
    alu_d = rand_bcd(); alu_neg = 1'($urandom); alu_ovf = 1'($urandom);
    alu_delay = dly;
    s0 = start_cnt;
    press_to_show(t);
    ok = (dly > 0 && dly <= TO);
    m_d = ok ? alu_d : 10'd0; m_dn = ok ? alu_neg : 1'b0; m_do = ok ? alu_ovf : 1'b1;
    m_st = 3'd4;
    chk({t, ".starts"}, start_cnt - s0, 1);
    chk({t, ".wait_len"}, wait_len, ok ? dly : TO);
    check_model(t);
  endtask

  initial begin : main
    tick(3);
    rst = 1'b0;
    model_clear();
    tick(2);
    check_model("reset");
    // normal operation
    sw_val = 10'h123; sw_neg = 1'b1;
    press();
    m_a = 10'h123; m_an = 1; m_st = 3'd1;
    check_model("t1_a");
    sw_val = 10'h045; sw_neg = 1'b0; sw_op = 2'd0;
    alu_d = 10'h078; alu_neg = 1'b1; alu_ovf = 1'b0; alu_delay = 5;
    begin
      int s0;
      s0 = start_cnt;
      press_to_show("t1");
      chk("t1.starts", start_cnt - s0, 1);
    end
    m_b = 10'h045; m_bn = 0; m_op = 2'd0; m_d = 10'h078; m_dn = 1; m_do = 0; m_st = 3'd4;
    chk("t1.wait_len", wait_len, 5);
    check_model("t1_show");
    press();
    m_st = 3'd0;
    check_model("show_to_a");
    // invalid BCD in both load states
    sw_val = 10'h0A5;
    press();
    m_err = 1;
    check_model("bad_a");
    sw_val = 10'h095; sw_neg = 1'b0;
    press();
    m_a = 10'h095; m_an = 0; m_err = 0; m_st = 3'd1;
    check_model("good_a");
    sw_val = 10'h0B0;
    press();
    m_err = 1;
    check_model("bad_b");
    // ALU never answers
    m_b = rand_bcd(); m_bn = 1'($urandom); m_op = 2'($urandom);
    sw_val = m_b; sw_neg = m_bn; sw_op = m_op; alu_delay = -1;
    press_to_show("timeout");
    m_err = 0; m_d = '0; m_dn = 0; m_do = 1; m_st = 3'd4;
    chk("timeout.wait_len", wait_len, TO);
    check_model("timeout");
    press();
    m_st = 3'd0;
    run_calc(TO, "tie");
    press();
    run_calc(TO + 1, "late");
    press();
    m_st = 3'd0;
    check_model("late_back");
    for (int i = 0; i < 3; i++) begin
      run_calc(int'($urandom_range(1, TO)), "rand");
      press();
      m_st = 3'd0;
    end
    // bouncing key gives one press
    m_a = rand_bcd(); m_an = 1'($urandom);
    sw_val = m_a; sw_neg = m_an;
    for (int i = 0; i < 10; i++) begin key_n = ~key_n; tick(2); end
    press();
    m_st = 3'd1; m_err = 0;
    check_model("bounce");
    // clear during WAIT, then late done
    m_b = rand_bcd(); sw_val = m_b; alu_delay = -1;
    key_n = 1'b0;
    wait_state(3'd3, "clr_wait");
    clr_n = 1'b0;
    wait_state(3'd0, "clr_hit");
    key_n = 1'b1; clr_n = 1'b1;
    tick(DB + 8);
    model_clear();
    check_model("clr");
    late_req++;
    tick(3);
    check_model("late_done");
    // simultaneous clear and key
    sw_val = 10'h321; sw_neg = 1'b1;
    key_n = 1'b0; clr_n = 1'b0;
    tick(DB + 8);
    key_n = 1'b1; clr_n = 1'b1;
    tick(DB + 8);
    check_model("clr_key");
    // async reset mid-debounce
    sw_val = 10'h287; sw_neg = 1'b1;
    press();
    m_a = 10'h287; m_an = 1; m_st = 3'd1;
    check_model("pre_rst");
    key_n = 1'b0;
    tick(3);
    rst = 1'b1;
    #1;
    model_clear();
    check_model("rst_async");
    key_n = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(DB + 8);
    check_model("rst_after");
    sw_val = 10'h111; sw_neg = 1'b0;
    press();
    m_a = 10'h111; m_st = 3'd1;
    check_model("post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
- Top-level control FSM for the FPGA calculator.
- Captures operands A and B and the operation from the board switches on debounced key presses.
- Starts the multi-cycle ALU and waits for its done handshake, with a timeout.
- Holds the result and drives the seven-segment display decoder's operand, sign, result, overflow and show-result inputs.

Parameters:
- DEBOUNCE_CYCLES, 250000: stable-level cycles required before a key level is accepted (5 ms at 50 MHz).
- ALU_TIMEOUT, 1024: cycles waited for alu_done before the result is forced to error.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- key_n  in  1  raw "enter" pushbutton, active-low, asynchronous
- clr_n  in  1  raw "clear" pushbutton, active-low, asynchronous
- sw_val  in  10  operand magnitude as BCD: [9:8] hundreds 0-3, [7:4] tens, [3:0] units
- sw_neg  in  1  operand sign switch
- sw_op  in  2  operation select
- alu_done  in  1  one-cycle pulse, ALU result valid
- alu_d  in  10  ALU result magnitude, BCD
- alu_neg  in  1  ALU result sign
- alu_ovf  in  1  ALU overflow
- a_val  out  10  latched operand A
- a_neg  out  1  sign of A
- b_val  out  10  latched operand B
- b_neg  out  1  sign of B
- op  out  2  latched operation
- alu_start  out  1  one-cycle ALU start pulse
- d_val  out  10  held result
- d_neg  out  1  held result sign
- d_ovf  out  1  held overflow/error
- show  out  1  display selects result (display "key" input)
- bcd_err  out  1  last key press rejected due to invalid BCD
- state_dbg  out  3  current state encoding

Behaviour:
- Reset: every output is 0, and the FSM enters LOAD_A.
- Key input conditioning: 2-flop synchronizer, then debounce counter, then rising-edge detector.
  - Edge is detected on the press, i.e. the falling edge of key_n.
  - Produces key_p, a single-cycle pulse.
  - key_p appears DEBOUNCE_CYCLES+3 cycles after key_n goes stably low.
- Clear input conditioning: clr_n passes through the identical path, producing clr_p.
- BCD validity check on sw_val: valid iff sw_val[7:4] <= 9 and sw_val[3:0] <= 9. Hundreds digit is always valid (0-3).
- LOAD_A: show=0.
  - key_p with valid BCD: a_val<=sw_val, a_neg<=sw_neg, bcd_err<=0, next state LOAD_B.
  - key_p with invalid BCD: bcd_err<=1, stay in LOAD_A, a_val unchanged.
- LOAD_B: same validity rule.
  - Valid: b_val, b_neg and op<=sw_op are latched, bcd_err<=0, next state START.
- START: alu_start=1 for exactly this one cycle; timeout counter cleared; next state WAIT.
- WAIT:
  - alu_done: d_val<=alu_d, d_neg<=alu_neg, d_ovf<=alu_ovf, next state SHOW.
  - Otherwise the counter increments. When the counter reaches ALU_TIMEOUT-1 with no done: d_val<=0, d_neg<=0, d_ovf<=1, next state SHOW.
  - alu_done and timeout in the same cycle: done wins.
- SHOW: show=1. key_p: show<=0, next state LOAD_A. a/b/op/d registers are retained until overwritten.
- key_p in START or WAIT: ignored and not queued.
- alu_done outside WAIT: ignored.
- clr_p in any state:
  - a_val, b_val, a_neg, b_neg, op, d_*, bcd_err and show all <=0; next state LOAD_A.
  - Aborts WAIT; a later alu_done is ignored.
- clr_p and key_p in the same cycle: clr wins.
- Asynchronous rst mid-operation: identical to reset, including debounce counters and synchronizer flops cleared to the "released" level.
- State encoding: LOAD_A=0, LOAD_B=1, START=2, WAIT=3, SHOW=4.
- All outputs are registered except alu_start and show, which decode from state.

Decomposition:
- Package calc_pkg holds:
  - state enum (encoding above);
  - op codes ADD=0, SUB=1, MUL=2, DIV=3;
  - BCD_DIGIT_MAX=9;
  - BCD_W=10.
- Sub-module key_debounce (param DEBOUNCE_CYCLES; ports clk, rst, raw_n, press_p) is instantiated twice, once for key_n and once for clr_n.

Test Plan (DEBOUNCE_CYCLES=4, ALU_TIMEOUT=16):
1. Normal operation:
   - Stimulus: sw_val=10'h123, sw_neg=1, press; then sw_val=10'h045, sw_op=0, press; ALU model asserts done 5 cycles after start with alu_d=10'h078, alu_neg=1.
   - Response: a_val=123, a_neg=1, b_val=045, op=0, exactly one alu_start pulse, d_val=078, d_neg=1, show=1 in SHOW.
2. Invalid BCD:
   - Stimulus: in LOAD_A, sw_val=10'h0A5, press.
   - Response: bcd_err=1, state stays LOAD_A, a_val unchanged. Then sw_val=10'h095, press: bcd_err=0, state LOAD_B.
3. Bouncing key:
   - Stimulus: key_n toggles every 2 cycles for 20 cycles, then held low.
   - Response: exactly one key_p, one state advance.
4. ALU timeout:
   - Stimulus: alu_done never asserted.
   - Response: 16 cycles after alu_start, d_ovf=1, d_val=0, state SHOW. Also: done on the same cycle as timeout expiry gives d_ovf=alu_ovf.
5. Clear during WAIT:
   - Stimulus: clr pressed while in WAIT; alu_done arrives afterwards; also clr and key pressed simultaneously.
   - Response: clr gives state LOAD_A with all registers 0; late alu_done causes no change; simultaneous clr+key gives LOAD_A, not LOAD_B.
6. Reset mid-debounce and SHOW to LOAD_A:
   - Stimulus: rst asserted mid-debounce; separately, key press while in SHOW.
   - Response: rst clears all outputs to 0 immediately (asynchronously). Key in SHOW returns to LOAD_A with show=0 and d_val retained.
